load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-side producer of the MEM_READ word consumed by the writeback select. Accepts one load or store per command from the core control, issues a single word-aligned request on the data bus with a req/ack handshake, and drives byte strobes and lane-replicated store data. Extracts, aligns and sign/zero-extends load data into MEM_READ. Asserts LS_BUSY so the core stalls PC update and register write until LS_DONE.

Parameters:
TIMEOUT_CYCLES, 16, max cycles BUS_REQ is held without BUS_ACK before the access aborts with error (range 1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
LS_START  input  1  one-cycle command strobe; ignored while LS_BUSY=1
LS_WRITE  input  1  1=store, 0=load; sampled with LS_START
FUNCT3  input  3  RV32I width/sign code; sampled with LS_START
ADDR  input  32  byte address (ALU result); sampled with LS_START
STORE_DATA  input  32  rs2 value; sampled with LS_START
MEM_READ  output  32  extended load result, held until the next successful load
LS_BUSY  output  1  high from the cycle after LS_START until LS_DONE inclusive
LS_DONE  output  1  one-cycle completion pulse (success or error)
LS_ERR  output  1  one-cycle pulse coincident with LS_DONE on error
BUS_REQ  output  1  request valid; held until ack or timeout
BUS_WE  output  1  1=write
BUS_ADDR  output  32  {ADDR[31:2],2'b00}
BUS_WSTRB  output  4  byte-lane write enables (0000 for reads)
BUS_WDATA  output  32  lane-replicated store data
BUS_ACK  input  1  responder completion; ignored when BUS_REQ=0
BUS_RDATA  input  32  read word, valid in the BUS_ACK cycle

Behaviour:
- Reset: state IDLE; MEM_READ=0, LS_BUSY=0, LS_DONE=0, LS_ERR=0, BUS_REQ=0, BUS_WE=0, BUS_ADDR=0, BUS_WSTRB=0, BUS_WDATA=0. Reset mid-transaction drops BUS_REQ in the next cycle with no LS_DONE.
- States: IDLE, REQ, DONE, ERR.
- IDLE + LS_START: latch command. Legal and aligned -> REQ. Otherwise -> ERR; no bus activity.
- Legal loads: FUNCT3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- Misaligned: halfword with ADDR[0]=1; word with ADDR[1:0]!=00.
- REQ: BUS_REQ=1 with stable BUS_ADDR/BUS_WE/BUS_WSTRB/BUS_WDATA. BUS_ACK=1 -> DONE, capturing BUS_RDATA for loads. Wait counter reaches TIMEOUT_CYCLES with no ack -> ERR and BUS_REQ drops.
- DONE: LS_DONE=1 for one cycle. Loads update MEM_READ in this same cycle. Next state IDLE.
- ERR: LS_DONE=1 and LS_ERR=1 for one cycle. MEM_READ unchanged. Next state IDLE.
- Latency: LS_START at cycle 0, BUS_REQ high at cycle 1. Ack at cycle k gives LS_DONE at cycle k+1. With zero-wait ack (k=1), LS_DONE is at cycle 2. Error detected at decode gives LS_DONE at cycle 1.
- LS_BUSY=1 in REQ, DONE and ERR states.
- Store lanes, with o=ADDR[1:0]:
  - SB: WSTRB=0001<<o, WDATA={4{rs2[7:0]}}
  - SH: WSTRB=0011<<o, WDATA={2{rs2[15:0]}}
  - SW: WSTRB=1111, WDATA=rs2
- Loads: select byte lane o or halfword lane o[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- LS_START while busy: ignored and not queued.

Test Plan:
- LW ADDR=0x100, ack at cycle 1 with RDATA=0xDEADBEEF -> BUS_ADDR=0x100, WSTRB=0000; LS_DONE at cycle 2; MEM_READ=0xDEADBEEF.
- LB ADDR=0x103 and LBU ADDR=0x103 with RDATA=0x80FF1234 -> MEM_READ=0xFFFFFF80 and 0x00000080 respectively.
- SB ADDR=0x202 rs2=0x12345678 -> BUS_ADDR=0x200, WSTRB=0100, WDATA=0x78787878, BUS_WE=1. Then SH ADDR=0x202 -> WSTRB=1100, WDATA=0x56785678.
- LW ADDR=0x102, and separately FUNCT3=011 -> no BUS_REQ; LS_DONE and LS_ERR at cycle 1; MEM_READ keeps its previous value.
- No ack, TIMEOUT_CYCLES=4 -> BUS_REQ high for exactly 4 cycles, then LS_DONE+LS_ERR. A late BUS_ACK after BUS_REQ drops is ignored.
- rst asserted in cycle 2 of a pending request -> BUS_REQ=0 and LS_BUSY=0 next cycle, no LS_DONE. A second LS_START issued while busy produces no extra transaction.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: issues one word-aligned data-bus request per command and
// produces the aligned, extended load result on MEM_READ.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LS_START,
  input  logic        LS_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] STORE_DATA,
  output logic [31:0] MEM_READ,
  output logic        LS_BUSY,
  output logic        LS_DONE,
  output logic        LS_ERR,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;
  logic        write_reg;
  logic [31:0] mem_read_reg;
  logic        bus_we_reg;
  logic [31:0] bus_addr_reg;
  logic [3:0]  bus_wstrb_reg;
  logic [31:0] bus_wdata_reg;

  logic        cmd_legal, cmd_aligned, cmd_ok;
  logic [3:0]  wstrb_next;
  logic [31:0] wdata_next;
  logic [31:0] rdata_shifted;
  logic [15:0] rdata_half;
  logic [31:0] load_value;

  // Command decode on the raw inputs, used only in the LS_START cycle.
  always_comb begin
    cmd_legal = LS_WRITE ? (FUNCT3 inside {3'b000, 3'b001, 3'b010})
                         : (FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (FUNCT3[1:0])
      2'b01:   cmd_aligned = !ADDR[0];
      2'b10:   cmd_aligned = (ADDR[1:0] == 2'b00);
      default: cmd_aligned = 1'b1;
    endcase
    cmd_ok = cmd_legal && cmd_aligned;

    wstrb_next = 4'b0000;
    wdata_next = 32'h0;
    if (LS_WRITE) begin
      case (FUNCT3[1:0])
        2'b00: begin
          wstrb_next = 4'b0001 << ADDR[1:0];
          wdata_next = {4{STORE_DATA[7:0]}};
        end
        2'b01: begin
          wstrb_next = 4'b0011 << ADDR[1:0];
          wdata_next = {2{STORE_DATA[15:0]}};
        end
        default: begin
          wstrb_next = 4'b1111;
          wdata_next = STORE_DATA;
        end
      endcase
    end
  end

  // Lane extraction and extension of the returned word.
  always_comb begin
    rdata_shifted = BUS_RDATA >> {offset_reg, 3'b000};
    rdata_half    = offset_reg[1] ? BUS_RDATA[31:16] : BUS_RDATA[15:0];
    case (funct3_reg)
      3'b000:  load_value = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_value = {{16{rdata_half[15]}}, rdata_half};
      3'b100:  load_value = {24'h0, rdata_shifted[7:0]};
      3'b101:  load_value = {16'h0, rdata_half};
      default: load_value = BUS_RDATA;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (LS_START) state_next = cmd_ok ? REQ : ERR;
      REQ: begin
        if (BUS_ACK)
          state_next = DONE;
        else if (wait_cnt_reg == LAST_WAIT)
          state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg  <= 8'h0;
      funct3_reg    <= 3'b000;
      offset_reg    <= 2'b00;
      write_reg     <= 1'b0;
      mem_read_reg  <= 32'h0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= 32'h0;
      bus_wstrb_reg <= 4'b0000;
      bus_wdata_reg <= 32'h0;
    end else begin
      if (state_reg == IDLE && LS_START) begin
        funct3_reg   <= FUNCT3;
        offset_reg   <= ADDR[1:0];
        write_reg    <= LS_WRITE;
        wait_cnt_reg <= 8'h0;
        // Rejected commands never touch the bus.
        if (cmd_ok) begin
          bus_we_reg    <= LS_WRITE;
          bus_addr_reg  <= {ADDR[31:2], 2'b00};
          bus_wstrb_reg <= wstrb_next;
          bus_wdata_reg <= wdata_next;
        end
      end
      if (state_reg == REQ) begin
        wait_cnt_reg <= wait_cnt_reg + 8'h1;
        if (BUS_ACK && !write_reg)
          mem_read_reg <= load_value;
      end
    end
  end

  assign MEM_READ  = mem_read_reg;
  assign LS_BUSY   = (state_reg != IDLE);
  assign LS_DONE   = (state_reg == DONE) || (state_reg == ERR);
  assign LS_ERR    = (state_reg == ERR);
  assign BUS_REQ   = (state_reg == REQ);
  assign BUS_WE    = bus_we_reg;
  assign BUS_ADDR  = bus_addr_reg;
  assign BUS_WSTRB = bus_wstrb_reg;
  assign BUS_WDATA = bus_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases then randomized transactions
// checked against a byte-level reference model.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        LS_START, LS_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR, STORE_DATA;
  logic [31:0] MEM_READ;
  logic        LS_BUSY, LS_DONE, LS_ERR;
  logic        BUS_REQ, BUS_WE;
  logic [31:0] BUS_ADDR, BUS_WDATA;
  logic [3:0]  BUS_WSTRB;
  logic        BUS_ACK;
  logic [31:0] BUS_RDATA;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_txn = 0;
  logic [31:0] mem_exp = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .LS_START(LS_START), .LS_WRITE(LS_WRITE), .FUNCT3(FUNCT3),
    .ADDR(ADDR), .STORE_DATA(STORE_DATA),
    .MEM_READ(MEM_READ), .LS_BUSY(LS_BUSY), .LS_DONE(LS_DONE), .LS_ERR(LS_ERR),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WSTRB(BUS_WSTRB), .BUS_WDATA(BUS_WDATA),
    .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int size_of(input bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_legal(input bit w, input bit [2:0] f3);
    if (w) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit [31:0] load_result(input bit [2:0] f3, input int o, input bit [31:0] rdata);
    int sz = size_of(f3);
    bit [31:0] raw = rdata >> (8 * o);
    if (sz == 4) return rdata;
    raw = (sz == 1) ? (raw & 32'hFF) : (raw & 32'hFFFF);
    if (!f3[2] && raw >= (32'd1 << (8 * sz - 1)))
      raw = raw - (32'd1 << (8 * sz));
    return raw;
  endfunction

  function automatic bit [3:0] strb_model(input bit [2:0] f3, input int o);
    bit [3:0] s = 4'b0;
    int sz = size_of(f3);
    for (int k = 0; k < 4; k++)
      if (k >= o && k < o + sz) s[k] = 1'b1;
    return s;
  endfunction

  function automatic bit [31:0] wdata_model(input bit [2:0] f3, input bit [31:0] sdata);
    bit [31:0] wd = 32'h0;
    int sz = size_of(f3);
    for (int k = 0; k < 4; k++)
      wd[8*k +: 8] = sdata[8*(k % sz) +: 8];
    return wd;
  endfunction

  // One command; delay = idle cycles before ack, delay >= T means no ack.
  task automatic do_txn(input bit w, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] sdata, input bit [31:0] rdata, input int delay);
    int o = int'(addr[1:0]);
    int sz = size_of(f3);
    bit ok = is_legal(w, f3) && ((addr % sz) == 0);
    int n_wait = (delay < T) ? delay : T;
    string kind;
    @(posedge clk); #1;
    LS_START = 1'b1; LS_WRITE = w; FUNCT3 = f3; ADDR = addr; STORE_DATA = sdata;
    @(posedge clk); #1;
    LS_START = 1'b0; LS_WRITE = $urandom; FUNCT3 = 3'($urandom); ADDR = $urandom; STORE_DATA = $urandom;
    check_val("busy", LS_BUSY, 1);
    if (!ok) begin
      kind = "reject";
      check_val("dec_done", LS_DONE, 1);
      check_val("dec_err", LS_ERR, 1);
      check_val("dec_req", BUS_REQ, 0);
      check_val("dec_mem", MEM_READ, mem_exp);
    end else begin
      check_val("addr", BUS_ADDR, {addr[31:2], 2'b00});
      check_val("we", BUS_WE, 32'(w));
      check_val("wstrb", BUS_WSTRB, w ? strb_model(f3, o) : 4'b0000);
      if (w) check_val("wdata", BUS_WDATA, wdata_model(f3, sdata));
      for (int i = 0; i < n_wait; i++) begin
        check_val("req_held", BUS_REQ, 1);
        BUS_RDATA = $urandom;
        @(posedge clk); #1;
      end
      if (delay < T) begin
        kind = "ok";
        check_val("req_ack", BUS_REQ, 1);
        BUS_ACK = 1'b1; BUS_RDATA = rdata;
        @(posedge clk); #1;
        BUS_ACK = 1'b0; BUS_RDATA = $urandom;
        if (!w) mem_exp = load_result(f3, o, rdata);
        check_val("done", LS_DONE, 1);
        check_val("done_err", LS_ERR, 0);
        check_val("mem", MEM_READ, mem_exp);
      end else begin
        kind = "timeout";
        check_val("to_done", LS_DONE, 1);
        check_val("to_err", LS_ERR, 1);
        check_val("to_req", BUS_REQ, 0);
        check_val("to_mem", MEM_READ, mem_exp);
        BUS_ACK = 1'b1; BUS_RDATA = rdata;
      end
    end
    @(posedge clk); #1;
    check_val("idle_done", LS_DONE, 0);
    check_val("idle_busy", LS_BUSY, 0);
    check_val("idle_mem", MEM_READ, mem_exp);
    BUS_ACK = 1'b0;
    n_txn++;
    $display("txn %0d: %s we=%0d f3=%0d addr=%h delay=%0d mem_read=%h",
             n_txn, kind, w, f3, addr, delay, MEM_READ);
  endtask

  initial begin
    rst = 1'b1; LS_START = 1'b0; LS_WRITE = 1'b0; FUNCT3 = 3'b0;
    ADDR = 32'h0; STORE_DATA = 32'h0; BUS_ACK = 1'b0; BUS_RDATA = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_mem", MEM_READ, 0);
    check_val("rst_busy", LS_BUSY, 0);
    check_val("rst_done", LS_DONE, 0);
    check_val("rst_req", BUS_REQ, 0);
    check_val("rst_addr", BUS_ADDR, 0);
    check_val("rst_wstrb", BUS_WSTRB, 0);
    check_val("rst_wdata", BUS_WDATA, 0);

    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check_val("lw_plan", MEM_READ, 32'hDEADBEEF);
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1);
    check_val("lb_plan", MEM_READ, 32'hFFFFFF80);
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2);
    check_val("lbu_plan", MEM_READ, 32'h00000080);
    do_txn(1'b1, 3'b000, 32'h202, 32'h12345678, 32'h0, 0);
    do_txn(1'b1, 3'b001, 32'h202, 32'h12345678, 32'h0, 3);
    do_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    do_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    do_txn(1'b0, 3'b010, 32'h104, 32'h0, 32'h11111111, T);

    // Reset during a pending request, with a stray LS_START while busy.
    @(posedge clk); #1;
    LS_START = 1'b1; LS_WRITE = 1'b0; FUNCT3 = 3'b010; ADDR = 32'h400;
    @(posedge clk); #1;
    LS_START = 1'b1; LS_WRITE = 1'b1; ADDR = 32'h500;
    check_val("rstmid_req1", BUS_REQ, 1);
    @(posedge clk); #1;
    LS_START = 1'b0;
    check_val("rstmid_req2", BUS_REQ, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_exp = 32'h0;
    check_val("rstmid_req", BUS_REQ, 0);
    check_val("rstmid_busy", LS_BUSY, 0);
    check_val("rstmid_done", LS_DONE, 0);
    check_val("rstmid_addr", BUS_ADDR, 0);
    check_val("rstmid_mem", MEM_READ, 0);
    $display("txn %0d: reset mid-request", ++n_txn);

    // Busy-time LS_START must not spawn another access.
    @(posedge clk); #1;
    LS_START = 1'b1; LS_WRITE = 1'b0; FUNCT3 = 3'b001; ADDR = 32'h602;
    @(posedge clk); #1;
    LS_START = 1'b1; LS_WRITE = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h700;
    BUS_ACK = 1'b1; BUS_RDATA = 32'h9ABC0001;
    @(posedge clk); #1;
    LS_START = 1'b0; BUS_ACK = 1'b0;
    mem_exp = 32'hFFFF9ABC;
    check_val("busy_done", LS_DONE, 1);
    check_val("busy_mem", MEM_READ, mem_exp);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("busy_noreq", BUS_REQ, 0);
      check_val("busy_idle", LS_BUSY, 0);
    end
    $display("txn %0d: start-while-busy ignored", ++n_txn);

    for (int n = 0; n < 150; n++) begin
      bit w = 1'($urandom);
      bit [2:0] f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (w ? 3'($urandom_range(0, 2))
                     : 3'($urandom_range(0, 5)));
      do_txn(w, f3, $urandom, $urandom, $urandom, $urandom_range(0, T + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
